// File: rtl/feistel_cipher_iter_pkg.sv
// -----------------------------------------------------------------------------
// feistel_pkg
// Shared types and pure helper functions for the iterative Feistel cipher.
//   state_t    : controller states (IDLE, BUSY, DONE)
//   MODE_ENC/DEC : values of the mode bit
//   rotl_h     : left rotate inside an h-bit field
//   round_key  : K_i = rotl(key, i mod h) ^ i (i truncated to h bits)
//   round_f    : F(R, K) = (R + K) ^ rotl(R, rot), all modulo 2^h
// The functions work on a MAX_H-wide carrier so one definition serves every
// half-width; callers pass the half width h as a constant and keep the low h
// bits of the result.
// -----------------------------------------------------------------------------
package feistel_pkg;

   localparam int MAX_H = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_ENC = 1'b0;
   localparam logic MODE_DEC = 1'b1;

   typedef logic [MAX_H-1:0] word_t;

   function automatic word_t mask_h(input int h);
      if (h >= MAX_H) return '1;
      return (word_t'(1) << h) - word_t'(1);
   endfunction

   function automatic word_t rotl_h(input word_t x, input int amt, input int h);
      word_t xm;
      xm = x & mask_h(h);
      // A zero rotate would otherwise shift right by the full field width.
      if (amt == 0) return xm;
      return ((xm << amt) | (xm >> (h - amt))) & mask_h(h);
   endfunction

   function automatic word_t round_key(input word_t key, input int i, input int h);
      return rotl_h(key, i % h, h) ^ (word_t'(i) & mask_h(h));
   endfunction

   function automatic word_t round_f(input word_t r, input word_t k, input int rot, input int h);
      return ((r + k) ^ rotl_h(r, rot, h)) & mask_h(h);
   endfunction

endpackage

// File: rtl/feistel_cipher_iter_if.sv
// -----------------------------------------------------------------------------
// feistel_cipher_iter_if
// Block input and result output of the Feistel core.
//   in_valid/in_ready  : input block handshake
//   in_data/key/mode   : block, half-width key, 0 = encrypt / 1 = decrypt
//   out_valid/out_ready: result handshake
//   out_data           : result block
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high. The source holds valid and its payload until that edge; ready may
// depend on state only, never on valid.
// master = block source / result sink, slave = cipher core.
// -----------------------------------------------------------------------------
interface feistel_cipher_iter_if #(
   parameter int DATA_W = 32
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_W-1:0]     in_data;
   logic [DATA_W/2-1:0]   in_key;
   logic                  in_mode;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_W-1:0]     out_data;

   modport master (
      output in_valid, in_data, in_key, in_mode, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, in_key, in_mode, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/feistel_cipher_iter_round_comb.sv
// -----------------------------------------------------------------------------
// feistel_round_comb
// One combinational Feistel round with mode select.
//   l, r    : current halves
//   key     : cipher key (half width)
//   idx     : round index i
//   mode    : 0 = encrypt step, 1 = decrypt step
//   l_next, r_next : halves after the round
// Encrypt: (L, R) -> (R, L ^ F(R, K_i))
// Decrypt: (L, R) -> (R ^ F(L, K_i), L)
// -----------------------------------------------------------------------------
module feistel_round_comb
   import feistel_pkg::*;
#(
   parameter int H   = 16,
   parameter int ROT = 3,
   parameter int IW  = 5
) (
   input  logic [H-1:0]  l,
   input  logic [H-1:0]  r,
   input  logic [H-1:0]  key,
   input  logic [IW-1:0] idx,
   input  logic          mode,
   output logic [H-1:0]  l_next,
   output logic [H-1:0]  r_next
);

   logic [H-1:0] k;
   logic [H-1:0] f_in;
   logic [H-1:0] f;

   always_comb begin
      k    = H'(round_key(word_t'(key), int'(idx), H));
      // Decrypt runs F on the left half so that each step undoes one encrypt step.
      f_in = (mode == MODE_DEC) ? l : r;
      f    = H'(round_f(word_t'(f_in), word_t'(k), ROT, H));
      if (mode == MODE_DEC) begin
         l_next = r ^ f;
         r_next = l;
      end else begin
         l_next = r;
         r_next = l ^ f;
      end
   end

endmodule

// File: rtl/feistel_cipher_iter.sv
// -----------------------------------------------------------------------------
// feistel_cipher_iter
// Iterative Feistel block cipher, one round per clock, runtime key and mode.
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   bus        : slave side of feistel_cipher_iter_if (input + result handshakes)
//   state_dbg  : current controller state, for observation only
// Flow: IDLE accepts a block, BUSY runs ROUNDS rounds, DONE presents the
// registered result until it is taken. Key, mode and halves are latched on
// accept, so input changes during BUSY do not affect the block in flight.
// -----------------------------------------------------------------------------
module feistel_cipher_iter
   import feistel_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ROUNDS = 16,
   parameter int ROT    = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   feistel_cipher_iter_if.slave  bus,
   output state_t                state_dbg
);

   localparam int H  = DATA_W / 2;
   localparam int CW = $clog2(ROUNDS + 1);
   localparam logic [CW-1:0] LAST_IDX = CW'(ROUNDS - 1);

   state_t            state_q;
   state_t            state_d;
   logic [H-1:0]      l_q;
   logic [H-1:0]      r_q;
   logic [H-1:0]      key_q;
   logic              mode_q;
   logic [CW-1:0]     cnt_q;
   logic [DATA_W-1:0] out_q;
   logic [H-1:0]      l_nx;
   logic [H-1:0]      r_nx;
   logic              last_round;

   feistel_round_comb #(
      .H   (H),
      .ROT (ROT),
      .IW  (CW)
   ) u_round (
      .l      (l_q),
      .r      (r_q),
      .key    (key_q),
      .idx    (cnt_q),
      .mode   (mode_q),
      .l_next (l_nx),
      .r_next (r_nx)
   );

   // Encrypt counts 0 up to ROUNDS-1, decrypt counts ROUNDS-1 down to 0.
   assign last_round = (mode_q == MODE_DEC) ? (cnt_q == '0) : (cnt_q == LAST_IDX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.in_valid)  state_d = BUSY;
         BUSY:    if (last_round)    state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default:                    state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         l_q    <= '0;
         r_q    <= '0;
         key_q  <= '0;
         mode_q <= MODE_ENC;
         cnt_q  <= '0;
         out_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  l_q    <= bus.in_data[DATA_W-1:H];
                  r_q    <= bus.in_data[H-1:0];
                  key_q  <= bus.in_key;
                  mode_q <= bus.in_mode;
                  cnt_q  <= (bus.in_mode == MODE_DEC) ? LAST_IDX : '0;
               end
            end
            BUSY: begin
               l_q <= l_nx;
               r_q <= r_nx;
               if (last_round) begin
                  // No final swap: the result is the halves as the last round leaves them.
                  out_q <= {l_nx, r_nx};
               end else if (mode_q == MODE_DEC) begin
                  cnt_q <= cnt_q - CW'(1);
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.out_data  = out_q;
   assign state_dbg     = state_q;

endmodule

// File: tb/tb_feistel_cipher_iter.sv
// -----------------------------------------------------------------------------
// tb_feistel_cipher_iter
// Four cipher instances with different parameter sets share one clock/reset:
//   0: DATA_W=32 ROUNDS=16  ROT=3   (default)
//   1: DATA_W=32 ROUNDS=1   ROT=3
//   2: DATA_W=8  ROUNDS=1   ROT=3
//   3: DATA_W=64 ROUNDS=255 ROT=31
// Results are compared with a reference model computed from the cipher rules.
// -----------------------------------------------------------------------------
module tb_feistel_cipher_iter;
   import feistel_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // ---------------- stimulus / observation ----------------
   logic        vld  [4];
   logic        mode [4];
   logic        ordy [4];
   logic [63:0] dat  [4];
   logic [31:0] key  [4];
   wire         rdy  [4];
   wire         ovld [4];
   wire  [63:0] odat [4];
   state_t      st_a, st_b, st_c, st_d;

   int n_chk = 0;
   int n_err = 0;

   feistel_cipher_iter_if #(.DATA_W(32)) if_a ();
   feistel_cipher_iter_if #(.DATA_W(32)) if_b ();
   feistel_cipher_iter_if #(.DATA_W(8))  if_c ();
   feistel_cipher_iter_if #(.DATA_W(64)) if_d ();

   assign if_a.in_valid = vld[0];  assign if_a.in_mode = mode[0];  assign if_a.out_ready = ordy[0];
   assign if_a.in_data  = dat[0][31:0];  assign if_a.in_key = key[0][15:0];
   assign rdy[0] = if_a.in_ready;  assign ovld[0] = if_a.out_valid;  assign odat[0] = 64'(if_a.out_data);

   assign if_b.in_valid = vld[1];  assign if_b.in_mode = mode[1];  assign if_b.out_ready = ordy[1];
   assign if_b.in_data  = dat[1][31:0];  assign if_b.in_key = key[1][15:0];
   assign rdy[1] = if_b.in_ready;  assign ovld[1] = if_b.out_valid;  assign odat[1] = 64'(if_b.out_data);

   assign if_c.in_valid = vld[2];  assign if_c.in_mode = mode[2];  assign if_c.out_ready = ordy[2];
   assign if_c.in_data  = dat[2][7:0];  assign if_c.in_key = key[2][3:0];
   assign rdy[2] = if_c.in_ready;  assign ovld[2] = if_c.out_valid;  assign odat[2] = 64'(if_c.out_data);

   assign if_d.in_valid = vld[3];  assign if_d.in_mode = mode[3];  assign if_d.out_ready = ordy[3];
   assign if_d.in_data  = dat[3];  assign if_d.in_key = key[3];
   assign rdy[3] = if_d.in_ready;  assign ovld[3] = if_d.out_valid;  assign odat[3] = if_d.out_data;

   feistel_cipher_iter #(.DATA_W(32), .ROUNDS(16),  .ROT(3))  dut_a (.clk(clk), .rst(rst), .bus(if_a), .state_dbg(st_a));
   feistel_cipher_iter #(.DATA_W(32), .ROUNDS(1),   .ROT(3))  dut_b (.clk(clk), .rst(rst), .bus(if_b), .state_dbg(st_b));
   feistel_cipher_iter #(.DATA_W(8),  .ROUNDS(1),   .ROT(3))  dut_c (.clk(clk), .rst(rst), .bus(if_c), .state_dbg(st_c));
   feistel_cipher_iter #(.DATA_W(64), .ROUNDS(255), .ROT(31)) dut_d (.clk(clk), .rst(rst), .bus(if_d), .state_dbg(st_d));

   function automatic int cfg_w(input int sel);
      case (sel) 0: return 32; 1: return 32; 2: return 8; default: return 64; endcase
   endfunction
   function automatic int cfg_r(input int sel);
      case (sel) 0: return 16; 1: return 1; 2: return 1; default: return 255; endcase
   endfunction
   function automatic int cfg_rot(input int sel);
      case (sel) 3: return 31; default: return 3; endcase
   endfunction
   function automatic logic [63:0] wmask(input int w);
      if (w >= 64) return '1;
      return (64'd1 << w) - 64'd1;
   endfunction

   // ---------------- reference model ----------------
   function automatic logic [63:0] rot_left(input logic [63:0] x, input int s, input int h);
      logic [63:0] m;
      logic [63:0] xm;
      m  = wmask(h);
      xm = x & m;
      if (s == 0) return xm;
      return ((xm << s) | (xm >> (h - s))) & m;
   endfunction

   function automatic logic [63:0] fmod(input logic [63:0] x, input logic [63:0] k, input int rot, input int h);
      return ((x + k) & wmask(h)) ^ rot_left(x, rot, h);
   endfunction

   function automatic logic [63:0] model(input int sel, input logic [63:0] d, input logic [63:0] k, input logic m);
      int h, rounds, rot;
      logic [63:0] msk, l, r, t, ki;
      h = cfg_w(sel) / 2;  rounds = cfg_r(sel);  rot = cfg_rot(sel);
      msk = wmask(h);
      l = (d >> h) & msk;
      r = d & msk;
      if (!m) begin
         for (int i = 0; i < rounds; i++) begin
            ki = rot_left(k, i % h, h) ^ (64'(i) & msk);
            t  = l ^ fmod(r, ki, rot, h);
            l  = r;
            r  = t;
         end
      end else begin
         for (int i = rounds - 1; i >= 0; i--) begin
            ki = rot_left(k, i % h, h) ^ (64'(i) & msk);
            t  = r ^ fmod(l, ki, rot, h);
            r  = l;
            l  = t;
         end
      end
      return (l << h) | r;
   endfunction

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Called at a negedge; returns at the negedge following the accepting edge.
   task automatic send(input int sel, input logic [63:0] d, input logic [63:0] k, input logic m);
      int n;
      vld[sel]  = 1'b1;
      dat[sel]  = d;
      key[sel]  = k[31:0];
      mode[sel] = m;
      n = 0;
      while (!rdy[sel] && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("accept_timeout", 64'(n), 64'd0);
      @(negedge clk);
      vld[sel] = 1'b0;
   endtask

   // Counts edges after accept until out_valid; optionally scrambles inputs meanwhile.
   task automatic wait_out(input int sel, input bit scramble, output int lat);
      lat = 0;
      while (!ovld[sel] && lat < 400) begin
         if (scramble) begin
            dat[sel]  = {$urandom, $urandom};
            key[sel]  = $urandom;
            mode[sel] = 1'($urandom_range(0, 1));
            vld[sel]  = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         lat++;
      end
      vld[sel] = 1'b0;
      if (lat >= 400) check("result_timeout", 64'(lat), 64'(cfg_r(sel)));
   endtask

   task automatic take(input int sel);
      ordy[sel] = 1'b1;
      @(negedge clk);
      ordy[sel] = 1'b0;
   endtask

   task automatic run_block(input int sel, input logic [63:0] d, input logic [63:0] k, input logic m,
                            input bit scramble, output logic [63:0] res, output int lat);
      send(sel, d, k, m);
      wait_out(sel, scramble, lat);
      res = odat[sel];
      take(sel);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int          sel;
      logic [63:0] d;
      logic [63:0] k;
      logic        m;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs [9];

   initial begin
      logic [63:0] res, res2, pt, kk, hold;
      int          lat;
      bit          stale;

      rst = 1'b1;
      for (int s = 0; s < 4; s++) begin
         vld[s] = 1'b0;  mode[s] = 1'b0;  ordy[s] = 1'b0;  dat[s] = '0;  key[s] = '0;
      end

      vecs[0] = '{sel: 1, d: 64'h0000_0001, k: 64'h0, m: 1'b0, exp: 64'h0001_0009};
      vecs[1] = '{sel: 1, d: 64'h0001_0009, k: 64'h0, m: 1'b1, exp: 64'h0000_0001};
      vecs[2] = '{sel: 1, d: 64'h0,         k: 64'h0, m: 1'b0, exp: 64'h0};
      vecs[3] = '{sel: 1, d: 64'h0,         k: 64'h0, m: 1'b1, exp: 64'h0};
      vecs[4] = '{sel: 1, d: 64'h0000_0001, k: 64'h1, m: 1'b0, exp: 64'h0001_000A};
      vecs[5] = '{sel: 1, d: 64'h0001_000A, k: 64'h1, m: 1'b1, exp: 64'h0000_0001};
      vecs[6] = '{sel: 0, d: 64'h0123_4567, k: 64'hBEEF, m: 1'b0, exp: model(0, 64'h0123_4567, 64'hBEEF, 1'b0)};
      vecs[7] = '{sel: 0, d: 64'hDEAD_BEEF, k: 64'h1234, m: 1'b1, exp: model(0, 64'hDEAD_BEEF, 64'h1234, 1'b1)};
      vecs[8] = '{sel: 2, d: 64'hA5,        k: 64'h9,    m: 1'b0, exp: model(2, 64'hA5, 64'h9, 1'b0)};

      // Reset values, during and just after reset.
      repeat (3) @(negedge clk);
      for (int s = 0; s < 4; s++) begin
         check("rst_in_ready", 64'(rdy[s]), 64'd1);
         check("rst_out_valid", 64'(ovld[s]), 64'd0);
         check("rst_out_data", odat[s], 64'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      check("idle_state_a", 64'(st_a), 64'(IDLE));
      check("idle_in_ready_a", 64'(rdy[0]), 64'd1);
      check("idle_in_ready_d", 64'(rdy[3]), 64'd1);

      // Directed table.
      for (int v = 0; v < 9; v++) begin
         run_block(vecs[v].sel, vecs[v].d, vecs[v].k, vecs[v].m, 1'b0, res, lat);
         check($sformatf("vec%0d_data", v), res, vecs[v].exp);
         check($sformatf("vec%0d_latency", v), 64'(lat), 64'(cfg_r(vecs[v].sel)));
      end

      // Random round trips at default parameters.
      for (int n = 0; n < 1000; n++) begin
         pt = {32'h0, $urandom};
         kk = {48'h0, 16'($urandom)};
         run_block(0, pt, kk, 1'b0, 1'b0, res, lat);
         check("rt_enc_data", res, model(0, pt, kk, 1'b0));
         check("rt_enc_latency", 64'(lat), 64'd16);
         run_block(0, res, kk, 1'b1, 1'b0, res2, lat);
         check("rt_dec_data", res2, pt);
         check("rt_dec_latency", 64'(lat), 64'd16);
      end

      // Inputs churning while the block is in flight.
      for (int n = 0; n < 20; n++) begin
         pt = {32'h0, $urandom};
         kk = {48'h0, 16'($urandom)};
         send(0, pt, kk, 1'(n % 2));
         wait_out(0, 1'b1, lat);
         check("midflight_data", odat[0], model(0, pt, kk, 1'(n % 2)));
         check("midflight_latency", 64'(lat), 64'd16);
         take(0);
      end

      // Backpressure held in DONE while new blocks are offered.
      pt = 64'h1357_9BDF;
      kk = 64'h2468;
      send(0, pt, kk, 1'b0);
      wait_out(0, 1'b0, lat);
      hold = odat[0];
      check("bp_result", hold, model(0, pt, kk, 1'b0));
      for (int c = 0; c < 20; c++) begin
         vld[0] = 1'b1;
         dat[0] = {$urandom, $urandom};
         @(negedge clk);
         check("bp_data_stable", odat[0], hold);
         check("bp_out_valid", 64'(ovld[0]), 64'd1);
         check("bp_in_ready", 64'(rdy[0]), 64'd0);
      end
      vld[0]  = 1'b0;
      ordy[0] = 1'b1;
      @(negedge clk);
      ordy[0] = 1'b0;
      check("bp_release_in_ready", 64'(rdy[0]), 64'd1);
      check("bp_release_out_valid", 64'(ovld[0]), 64'd0);

      // Reset during round 7, then a clean block.
      send(0, 64'hCAFE_F00D, 64'h0F0F, 1'b0);
      repeat (7) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_out_valid", 64'(ovld[0]), 64'd0);
      check("midrst_out_data", odat[0], 64'd0);
      check("midrst_in_ready", 64'(rdy[0]), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      stale = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (ovld[0]) stale = 1'b1;
      end
      check("midrst_no_stale", 64'(stale), 64'd0);
      pt = 64'h0BAD_C0DE;
      kk = 64'h7777;
      run_block(0, pt, kk, 1'b0, 1'b0, res, lat);
      check("postrst_data", res, model(0, pt, kk, 1'b0));
      check("postrst_latency", 64'(lat), 64'd16);

      // Parameter sweep: narrow single-round and wide 255-round cores.
      for (int n = 0; n < 50; n++) begin
         pt = 64'($urandom_range(0, 255));
         kk = 64'($urandom_range(0, 15));
         run_block(2, pt, kk, 1'b0, 1'b0, res, lat);
         check("w8_enc_data", res, model(2, pt, kk, 1'b0));
         check("w8_enc_latency", 64'(lat), 64'd1);
         run_block(2, res, kk, 1'b1, 1'b0, res2, lat);
         check("w8_rt", res2, pt);
      end
      for (int n = 0; n < 8; n++) begin
         pt = {$urandom, $urandom};
         kk = {32'h0, $urandom};
         if (n == 0) begin
            pt = 64'h0;
            kk = 64'h0;
         end
         run_block(3, pt, kk, 1'b0, 1'b0, res, lat);
         check("w64_enc_data", res, model(3, pt, kk, 1'b0));
         check("w64_enc_latency", 64'(lat), 64'd255);
         run_block(3, res, kk, 1'b1, 1'b0, res2, lat);
         check("w64_rt", res2, pt);
         check("w64_dec_latency", 64'(lat), 64'd255);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
